// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state, instruction-class, pc_sel and RV32I opcode constants
// used by the sequencer, its opcode classifier, the program counter and the decoder.
package fetch_sequencer_pkg;
    typedef logic [2:0] state_t;
    localparam state_t S_FETCH   = 3'd0;
    localparam state_t S_DECODE  = 3'd1;
    localparam state_t S_EXECUTE = 3'd2;
    localparam state_t S_MEM     = 3'd3;
    localparam state_t S_WB      = 3'd4;
    localparam state_t S_HALT    = 3'd5;
    localparam state_t S_FAULT   = 3'd6;
    typedef enum logic [2:0] {CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_SYS} iclass_t;
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_REG   = 2'b10;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction/data memory handshake and datapath control bundle;
// master is the sequencer, slave is the surrounding datapath and memories.
interface fetch_sequencer_if;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       ir_load;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic       pc_write_en;
    logic [1:0] pc_sel;
    logic       halted;
    logic       fault;
    modport master(
        input  opcode, branch_taken, imem_ready, dmem_ready,
        output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_write_en, pc_sel, halted, fault
    );
    modport slave(
        output opcode, branch_taken, imem_ready, dmem_ready,
        input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_write_en, pc_sel, halted, fault
    );
endinterface

// File: rtl/fetch_sequencer_opcode_classifier.sv
// opcode_classifier: combinational RV32I opcode to instruction class plus illegal flag.
module opcode_classifier
    import fetch_sequencer_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_t    cls,
    output logic       illegal
);
    always_comb begin
        cls = CL_ALU;
        illegal = 1'b0;
        case (opcode)
            OP_REG, OP_IMM, OP_LUI, OP_AUIPC: cls = CL_ALU;
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_BRANCH: cls = CL_BRANCH;
            OP_JAL:    cls = CL_JAL;
            OP_JALR:   cls = CL_JALR;
            OP_SYSTEM: cls = CL_SYS;
            default:   illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control FSM with memory
// wait timeouts; HALT and FAULT are absorbing until reset.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst_n,
    fetch_sequencer_if.master bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    state_t        state, nxt;
    iclass_t       cls, dec_cls;
    logic          illegal, taken, waiting, timeout;
    logic [CW-1:0] cnt;
    opcode_classifier u_cls (.opcode(bus.opcode), .cls(dec_cls), .illegal(illegal));
    assign waiting = state == S_FETCH || state == S_MEM;
    assign timeout = cnt == CW'(MEM_TIMEOUT - 1);
    // Ready in the limit cycle wins over the timeout.
    always_comb begin
        nxt = state;
        case (state)
            S_FETCH:   nxt = bus.imem_ready ? S_DECODE : (timeout ? S_FAULT : S_FETCH);
            S_DECODE:  nxt = illegal ? S_FAULT : (dec_cls == CL_SYS ? S_HALT : S_EXECUTE);
            S_EXECUTE: nxt = (cls == CL_LOAD || cls == CL_STORE) ? S_MEM : S_WB;
            S_MEM:     nxt = bus.dmem_ready ? S_WB : (timeout ? S_FAULT : S_MEM);
            S_WB:      nxt = S_FETCH;
            default:   nxt = state;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            cnt   <= '0;
            cls   <= CL_ALU;
            taken <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= (waiting && nxt == state) ? cnt + 1'b1 : '0;
            if (state == S_DECODE) cls <= dec_cls;
            if (state == S_EXECUTE) taken <= cls == CL_BRANCH && bus.branch_taken;
        end
    end
    // Fetch-side outputs are gated by reset so nothing is requested while held.
    assign bus.imem_req    = rst_n && state == S_FETCH;
    assign bus.ir_load     = rst_n && state == S_FETCH && bus.imem_ready;
    assign bus.dmem_req    = state == S_MEM;
    assign bus.dmem_we     = state == S_MEM && cls == CL_STORE;
    assign bus.pc_write_en = state == S_WB;
    assign bus.rf_we       = state == S_WB && (cls == CL_ALU || cls == CL_LOAD || cls == CL_JAL || cls == CL_JALR);
    assign bus.pc_sel      = state != S_WB ? PC_PLUS4 :
                             (cls == CL_JAL || (cls == CL_BRANCH && taken)) ? PC_REL :
                             cls == CL_JALR ? PC_REG : PC_PLUS4;
    assign bus.halted      = state == S_HALT;
    assign bus.fault       = state == S_FAULT;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random instruction stream checked cycle by cycle against a
// phase-level model of each instruction's expected control outputs.
module tb_fetch_sequencer;
    localparam int TMO = 16;
    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_JAL = 4, K_JALR = 5, K_SYS = 6, K_ILL = 7;
    localparam logic [9:0] HALTV  = 10'b00_0000_0010;
    localparam logic [9:0] FAULTV = 10'b00_0000_0001;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [9:0] outs;
    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                             7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011};
    logic [6:0] op;
    int r, wi, wd;
    bit st;
    fetch_sequencer_if bus();
    fetch_sequencer #(.MEM_TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    assign outs = {bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.rf_we,
                   bus.pc_write_en, bus.pc_sel, bus.halted, bus.fault};

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b (imr irl dr dwe rfw pcw sel2 h f) t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [9:0] e(input bit imr, input bit irl, input bit dr, input bit dwe,
                                     input bit rfw, input bit pcw, input logic [1:0] ps);
        return {imr, irl, dr, dwe, rfw, pcw, ps, 2'b00};
    endfunction

    function automatic int kind_of(input logic [6:0] o);
        if (o == 7'b0110011 || o == 7'b0010011 || o == 7'b0110111 || o == 7'b0010111) return K_ALU;
        if (o == 7'b0000011) return K_LD;
        if (o == 7'b0100011) return K_ST;
        if (o == 7'b1100011) return K_BR;
        if (o == 7'b1101111) return K_JAL;
        if (o == 7'b1100111) return K_JALR;
        if (o == 7'b1110011) return K_SYS;
        return K_ILL;
    endfunction

    task automatic noise();
        bus.imem_ready   = 1'($urandom);
        bus.dmem_ready   = 1'($urandom);
        bus.branch_taken = 1'($urandom);
    endtask

    task automatic step(input string tag, input logic [9:0] want);
        @(negedge clk);
        check(tag, outs, want);
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input string tag, input logic [9:0] want);
        repeat (3) begin
            noise();
            step(tag, want);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async", outs, '0);
        noise();
        step("in_reset", '0);
        rst_n = 1'b1;
    endtask

    // One instruction: fetch waits wi cycles, data access waits wd cycles; abort >= 0
    // pulses reset in that MEM cycle instead of completing the access.
    task automatic play(input logic [6:0] o, input int wi_n, input int wd_n, input bit bt,
                        input int abort, output bit stopped);
        int k;
        bit got;
        logic [1:0] ps;
        bit rf;
        k = kind_of(o);
        stopped = 1'b1;
        bus.opcode = o;
        got = 1'b0;
        for (int c = 0; c < TMO && !got; c++) begin
            noise();
            got = c == wi_n;
            bus.imem_ready = got;
            step("fetch", e(1'b1, got, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        end
        if (!got) begin
            hold("imem_timeout", FAULTV);
            return;
        end
        noise();
        step("decode", '0);
        if (k == K_ILL) begin
            hold("illegal_hold", FAULTV);
            return;
        end
        if (k == K_SYS) begin
            hold("halt_hold", HALTV);
            return;
        end
        noise();
        bus.branch_taken = bt;
        step("execute", '0);
        if (k == K_LD || k == K_ST) begin
            got = 1'b0;
            for (int d = 0; d < TMO && !got; d++) begin
                if (d == abort) begin
                    do_reset();
                    stopped = 1'b0;
                    return;
                end
                noise();
                got = d == wd_n;
                bus.dmem_ready = got;
                step("mem", e(1'b0, 1'b0, 1'b1, k == K_ST, 1'b0, 1'b0, 2'b00));
            end
            if (!got) begin
                hold("dmem_timeout", FAULTV);
                return;
            end
        end
        rf = k == K_ALU || k == K_LD || k == K_JAL || k == K_JALR;
        ps = (k == K_JAL || (k == K_BR && bt)) ? 2'b01 : (k == K_JALR ? 2'b10 : 2'b00);
        noise();
        step("wb", e(1'b0, 1'b0, 1'b0, 1'b0, rf, 1'b1, ps));
        stopped = 1'b0;
    endtask

    task automatic run(input logic [6:0] o, input int wi_n, input int wd_n, input bit bt, input int abort);
        bit s;
        play(o, wi_n, wd_n, bt, abort, s);
        if (s) do_reset();
    endtask

    initial begin
        bus.opcode = '0;
        noise();
        @(negedge clk);
        check("reset", outs, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(7'b0110011, 0, 0, 1'b0, -1);
        run(7'b0000011, 0, 3, 1'b0, -1);
        run(7'b1100011, 0, 0, 1'b1, -1);
        run(7'b1100011, 0, 0, 1'b0, -1);
        run(7'b1100111, 0, 0, 1'b0, -1);
        run(7'b1101111, 2, 0, 1'b0, -1);
        run(7'b0100011, 1, 2, 1'b1, -1);
        run(7'b0110011, 15, 0, 1'b0, -1);
        run(7'b0110011, 16, 0, 1'b0, -1);
        run(7'b0000011, 0, 15, 1'b0, -1);
        run(7'b0100011, 0, 16, 1'b0, -1);
        run(7'b1111111, 0, 0, 1'b0, -1);
        run(7'b1110011, 0, 0, 1'b0, -1);
        run(7'b0100011, 0, 10, 1'b0, 2);
        run(7'b0110011, 0, 0, 1'b0, -1);
        for (int n = 0; n < 300; n++) begin
            r  = int'($urandom_range(0, 39));
            op = (r == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            wi = (r == 1) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            wd = (r == 2) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            play(op, wi, wd, 1'($urandom), (r == 3) ? int'($urandom_range(0, 2)) : -1, st);
            if (st) do_reset();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum cycles a memory request waits for ready before fault.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 opcode  input  7  opcode field of the instruction register (RV32I encoding), valid from DECODE onward.
REQ-005 branch_taken  input  1  branch comparison result, sampled in EXECUTE.
REQ-006 imem_ready  input  1  instruction memory completes the request this cycle.
REQ-007 dmem_ready  input  1  data memory completes the request this cycle.
REQ-008 imem_req  output  1  instruction fetch request at current pc.
REQ-009 ir_load  output  1  load instruction register this cycle.
REQ-010 dmem_req  output  1  data memory request.
REQ-011 dmem_we  output  1  data request is a write; meaningful only with dmem_req.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 pc_write_en  output  1  program counter updates this cycle.
REQ-014 pc_sel  output  2  next-pc source: 00 pc+4, 01 pc+immed, 10 rs1+immed; 11 never driven.
REQ-015 halted  output  1  sequencer stopped by SYSTEM instruction.
REQ-016 fault  output  1  sequencer stopped by illegal opcode or memory timeout.

Function
REQ-017 States SHALL be FETCH, DECODE, EXECUTE, MEM, WB, HALT, FAULT; all outputs Moore-decoded from state and registered class, except ir_load, which SHALL equal imem_ready in FETCH.
REQ-018 FETCH: imem_req=1 every cycle; on imem_ready=1 assert ir_load, go DECODE; else stay.
REQ-019 DECODE (1 cycle): latch instruction class from opcode: ALU (0110011, 0010011, 0110111, 0010111), LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, SYS 1110011; any other value -> FAULT next cycle.
REQ-020 DECODE with class SYS -> HALT; all other legal classes -> EXECUTE.
REQ-021 EXECUTE (1 cycle): LOAD/STORE -> MEM; others -> WB; branch_taken registered here for BRANCH.
REQ-022 MEM: dmem_req=1, dmem_we=1 for STORE else 0; on dmem_ready=1 go WB; else stay.
REQ-023 WB (1 cycle): pc_write_en=1; rf_we=1 for ALU, LOAD, JAL, JALR, else 0; pc_sel=01 for JAL or taken BRANCH, 10 for JALR, else 00; next state FETCH.
REQ-024 pc_write_en SHALL be asserted exactly once per completed instruction and only in WB.
REQ-025 Zero-wait latency: ALU/BRANCH/JAL/JALR 4 cycles, LOAD/STORE 5 cycles, FETCH-entry to FETCH-entry.
REQ-026 Wait counter: cleared on entry to FETCH or MEM, increments each cycle ready is low; reaching MEM_TIMEOUT with ready still low -> FAULT; ready arriving in the same cycle as the limit takes precedence (no fault).
REQ-027 HALT and FAULT SHALL be absorbing: only reset exits; all request/enable outputs 0; halted=1 in HALT, fault=1 in FAULT.
REQ-028 imem_req and dmem_req SHALL never be high in the same cycle.

Reset
REQ-029 While rst_n=0: state=FETCH, counter=0, class register=ALU, taken register=0.
REQ-030 Reset asserted mid-request SHALL drop imem_req/dmem_req immediately (asynchronously); all outputs 0 except imem_req=1 after release.
REQ-031 First imem_req SHALL occur in the first cycle after rst_n deasserts.

Structure
REQ-032 Shared package holds state enum, instruction-class enum, pc_sel encoding constants, and RV32I opcode constants (shared with the program counter and decoder).
REQ-033 One sub-module, opcode_classifier (combinational opcode -> class + illegal flag), instantiated once.

Verification
REQ-034 ADD (0110011), imem_ready=1 constant -> ir_load cycle 1, pc_write_en cycle 4 with pc_sel=00, rf_we=1; next imem_req cycle 5.
REQ-035 LW, dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, WB rf_we=1, pc_sel=00, 8 cycles total.
REQ-036 BEQ with branch_taken=1 then BEQ with 0 -> pc_sel=01 then 00, rf_we=0 both; JALR -> pc_sel=10, rf_we=1.
REQ-037 imem_ready held 0 with MEM_TIMEOUT=16 -> fault=1 after 16 waiting cycles, imem_req=0 thereafter; ready on the 16th cycle -> no fault.
REQ-038 Opcode 1111111 -> FAULT after DECODE; opcode 1110011 -> halted=1, no pc_write_en; both held until rst_n pulse returns to FETCH.
REQ-039 rst_n asserted during MEM of SW -> dmem_req drops same cycle; after release fresh fetch, no pc_write_en for aborted store.
